constant_memory_loader: RTL and testbench
=========================================

Name: constant_memory_loader

Overview:
- Sequencer that fills the CGRA constant memory before a kernel run.
- Accepts a load command (base address, word count), then streams data words over a valid/ready handshake.
- Drives the memory write port (address, line, enable) one word per accepted beat.
- Signals completion or rejection back to the host-side controller.

Parameters:
ADDR_WIDTH, 9, constant memory address width; depth = 2^ADDR_WIDTH words
DATA_WIDTH, 32, constant word width

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous, active-high reset
cmd_valid_i  input  1  load command valid
cmd_ready_o  output  1  loader can accept a command (high only in IDLE)
cmd_base_addr_i  input  ADDR_WIDTH  first write address
cmd_count_i  input  ADDR_WIDTH+1  number of words, 0..2^ADDR_WIDTH
data_valid_i  input  1  data word valid
data_ready_o  output  1  loader accepts data (high only in LOAD)
data_i  input  DATA_WIDTH  constant word
abort_i  input  1  cancel the load in progress
memory_write_addr_o  output  ADDR_WIDTH  to the memory write address
memory_line_o  output  DATA_WIDTH  to the memory write data
write_memory_en_o  output  1  to the memory write enable
busy_o  output  1  high while not IDLE
done_o  output  1  one-cycle pulse: load completed
error_o  output  1  one-cycle pulse: command rejected or aborted

Behaviour:
- Clock and reset: single clock clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: state=IDLE; all outputs 0 except cmd_ready_o=1; internal counters 0.
- FSM states:
  - IDLE:
    - cmd_ready_o=1.
    - On cmd_valid_i, latch base and count.
    - If base+count > 2^ADDR_WIDTH (computed ADDR_WIDTH+2 wide, no wrap): go to DONE, pulse error_o, perform no writes.
    - Else if count==0: go to DONE, pulse done_o.
    - Else: go to LOAD with addr=base, remaining=count.
  - LOAD:
    - data_ready_o=1.
    - On each data_valid_i beat, register memory_write_addr_o=addr, memory_line_o=data_i, write_memory_en_o=1 for exactly the next cycle.
    - Then addr+=1 and remaining-=1.
    - When the accepted beat has remaining==1, go to DONE and pulse done_o.
    - Cycles without data_valid_i: write_memory_en_o=0, no state change.
  - DONE:
    - Exactly one cycle, all ready signals low.
    - done_o or error_o is high during this cycle.
    - Then return to IDLE.
- Latency:
  - Data beat accepted at cycle N -> write enable at cycle N+1.
  - Last beat at N -> done_o at N+1, coincident with the final write_memory_en_o; cmd_ready_o=1 at N+2.
- Address: never wraps. The range check guarantees addr ≤ 2^ADDR_WIDTH-1 on every write. A write to the top word is legal.
- abort_i:
  - In LOAD, abort_i has priority over a simultaneous data beat: that beat is not accepted and not written.
  - Abort goes to DONE with error_o pulsed.
  - Words already written stay written.
  - abort_i is ignored in IDLE and DONE.
- rst_i mid-LOAD: next cycle state=IDLE and write_memory_en_o=0. A write registered in the same cycle as reset is suppressed.
- Outputs: memory_write_addr_o and memory_line_o hold their last values when enable is low (no X, no clear).
- busy_o = (state != IDLE).

Optional Feature:
CONST_LOADER_CHECKSUM_EN:
- When defined:
  - Adds output checksum_o [DATA_WIDTH-1:0], the running sum mod 2^DATA_WIDTH of every word written in the current load.
  - checksum_o is cleared on command acceptance and on reset.
  - The value is valid and stable from the done_o cycle until the next command is accepted.
- When undefined: port and adder are absent; behaviour is otherwise identical.

Decomposition:
- Package const_mem_pkg holds:
  - state enum (IDLE, LOAD, DONE);
  - default ADDR_WIDTH=9 and DATA_WIDTH=32 constants;
  - helper function computing depth = 1<<ADDR_WIDTH.
- No sub-module. The address counter and remaining counter live inline; the block is a single FSM plus a registered write stage.

Test Plan:
- Load base=0x010, count=4, data 0xA,0xB,0xC,0xD back-to-back -> enable high 4 consecutive cycles, addr 0x010..0x013, done_o on the cycle of the last write, then cmd_ready_o=1.
- Same load with data_valid_i toggling every other cycle -> writes only on accepted beats, addresses contiguous, done_o after the 4th write.
- base=0x1FE, count=2 -> writes at 0x1FE and 0x1FF, done_o. base=0x1FF, count=2 -> error_o pulse, zero writes.
- count=0 at any base -> done_o one cycle after the command, no write enable ever asserted.
- base=0, count=8; abort_i asserted together with the 3rd data beat -> only addr 0,1 written, error_o pulse, next command accepted.
- rst_i asserted during the 2nd beat of a 5-word load -> enable low next cycle, cmd_ready_o=1, busy_o=0. With CONST_LOADER_CHECKSUM_EN, load 0xFFFFFFFF,0x2 -> checksum_o=0x00000001.

Source files
------------

// File: rtl/const_mem_pkg.sv
// Shared types and sizing for the constant memory loader.
// No logic, no latency.
// No handshakes; types and constants only.
package const_mem_pkg;

    localparam int CMEM_ADDR_WIDTH = 9;
    localparam int CMEM_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of words in a constant memory with the given address width.
    function automatic int unsigned cmem_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/constant_memory_loader.sv
// Fills the CGRA constant memory from a (base, count) command followed by a stream of data words.
// Latency: data beat accepted at cycle N -> memory write at N+1; done_o coincides with the final write.
// Backpressure: cmd_ready_o only in IDLE, data_ready_o only in LOAD; optional checksum_o under CONST_LOADER_CHECKSUM_EN.
module constant_memory_loader
    import const_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = CMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = CMEM_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_base_addr_i,
    input  logic [ADDR_WIDTH:0]   cmd_count_i,
    input  logic                  data_valid_i,
    output logic                  data_ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  abort_i,
    output logic [ADDR_WIDTH-1:0] memory_write_addr_o,
    output logic [DATA_WIDTH-1:0] memory_line_o,
    output logic                  write_memory_en_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
`ifdef CONST_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum_o
`endif
);

    localparam int unsigned          DEPTH     = cmem_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH+1:0] DEPTH_EXT = DEPTH[ADDR_WIDTH+1:0];
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH:0]     remaining_q;
    logic [ADDR_WIDTH+1:0]   cmd_end;
    logic                    cmd_range_bad;

    // Two extra bits so base+count never wraps; a load ending exactly at the top word is legal.
    assign cmd_end       = {2'b00, cmd_base_addr_i} + {1'b0, cmd_count_i};
    assign cmd_range_bad = (cmd_end > DEPTH_EXT);

    assign cmd_ready_o  = (state_q == IDLE);
    assign data_ready_o = (state_q == LOAD);
    assign busy_o       = (state_q != IDLE);

    // Command FSM plus the registered write stage; reset also kills a write registered in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q             <= IDLE;
            addr_q              <= '0;
            remaining_q         <= '0;
            memory_write_addr_o <= '0;
            memory_line_o       <= '0;
            write_memory_en_o   <= 1'b0;
            done_o              <= 1'b0;
            error_o             <= 1'b0;
`ifdef CONST_LOADER_CHECKSUM_EN
            checksum_o          <= '0;
`endif
        end else begin
            write_memory_en_o <= 1'b0;
            done_o            <= 1'b0;
            error_o           <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        addr_q      <= cmd_base_addr_i;
                        remaining_q <= cmd_count_i;
`ifdef CONST_LOADER_CHECKSUM_EN
                        checksum_o  <= '0;
`endif
                        if (cmd_range_bad) begin
                            state_q <= DONE;
                            error_o <= 1'b1;
                        end else if (cmd_count_i == '0) begin
                            state_q <= DONE;
                            done_o  <= 1'b1;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    // Abort wins over a coincident beat: that beat is dropped, not written.
                    if (abort_i) begin
                        state_q <= DONE;
                        error_o <= 1'b1;
                    end else if (data_valid_i) begin
                        memory_write_addr_o <= addr_q;
                        memory_line_o       <= data_i;
                        write_memory_en_o   <= 1'b1;
                        addr_q              <= addr_q + ADDR_ONE;
                        remaining_q         <= remaining_q - CNT_ONE;
`ifdef CONST_LOADER_CHECKSUM_EN
                        checksum_o          <= checksum_o + data_i;
`endif
                        if (remaining_q == CNT_ONE) begin
                            state_q <= DONE;
                            done_o  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_constant_memory_loader.sv
// Randomized scoreboard bench for constant_memory_loader; driver pushes expected writes/completions, monitor pops.
// Monitor samples 1 time unit after each rising edge; driver changes inputs on falling edges.
// Checksum output is checked only when CONST_LOADER_CHECKSUM_EN is defined.
module tb_constant_memory_loader;

    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int DEPTH = 512;

    logic          clk_i;
    logic          rst_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [AW-1:0] cmd_base_addr_i;
    logic [AW:0]   cmd_count_i;
    logic          data_valid_i;
    logic          data_ready_o;
    logic [DW-1:0] data_i;
    logic          abort_i;
    logic [AW-1:0] memory_write_addr_o;
    logic [DW-1:0] memory_line_o;
    logic          write_memory_en_o;
    logic          busy_o;
    logic          done_o;
    logic          error_o;
`ifdef CONST_LOADER_CHECKSUM_EN
    logic [DW-1:0] checksum_o;
`endif

    constant_memory_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .cmd_valid_i         (cmd_valid_i),
        .cmd_ready_o         (cmd_ready_o),
        .cmd_base_addr_i     (cmd_base_addr_i),
        .cmd_count_i         (cmd_count_i),
        .data_valid_i        (data_valid_i),
        .data_ready_o        (data_ready_o),
        .data_i              (data_i),
        .abort_i             (abort_i),
        .memory_write_addr_o (memory_write_addr_o),
        .memory_line_o       (memory_line_o),
        .write_memory_en_o   (write_memory_en_o),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .error_o             (error_o)
`ifdef CONST_LOADER_CHECKSUM_EN
        ,
        .checksum_o          (checksum_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct packed {
        logic          is_err;
        logic          with_write;
        logic [DW-1:0] csum;
    } cpl_t;

    wr_t           wr_q[$];
    cpl_t          cpl_q[$];
    logic [DW-1:0] beats[$];
    int            tests = 0;
    int            fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_line = '0;
    logic          prev_cpl  = 1'b0;
    wr_t           mon_w;
    cpl_t          mon_c;

    always @(posedge clk_i) begin
        #1;
        if (rst_i) begin
            last_addr = '0;
            last_line = '0;
            prev_cpl  = 1'b0;
            check("rst_write_en", write_memory_en_o, 0);
            check("rst_cmd_ready", cmd_ready_o, 1);
            check("rst_data_ready", data_ready_o, 0);
            check("rst_busy", busy_o, 0);
            check("rst_done", done_o, 0);
            check("rst_error", error_o, 0);
            check("rst_addr", memory_write_addr_o, 0);
            check("rst_line", memory_line_o, 0);
        end else begin
            if (prev_cpl) begin
                check("cmd_ready_after_done", cmd_ready_o, 1);
                check("busy_after_done", busy_o, 0);
            end
            prev_cpl = 1'b0;
            if (write_memory_en_o) begin
                if (wr_q.size() == 0) begin
                    flag($sformatf("unexpected_write addr=0x%0h line=0x%0h", memory_write_addr_o, memory_line_o));
                end else begin
                    mon_w = wr_q.pop_front();
                    check("write_addr", memory_write_addr_o, mon_w.addr);
                    check("write_line", memory_line_o, mon_w.data);
                    last_addr = mon_w.addr;
                    last_line = mon_w.data;
                end
            end else begin
                check("hold_addr", memory_write_addr_o, last_addr);
                check("hold_line", memory_line_o, last_line);
            end
            if (done_o || error_o) begin
                prev_cpl = 1'b1;
                if (cpl_q.size() == 0) begin
                    flag($sformatf("unexpected_completion done=%0b error=%0b", done_o, error_o));
                end else begin
                    mon_c = cpl_q.pop_front();
                    check("cpl_error", error_o, mon_c.is_err);
                    check("cpl_done", done_o, !mon_c.is_err);
                    check("cpl_with_final_write", write_memory_en_o, mon_c.with_write);
                    check("cpl_cmd_ready_low", cmd_ready_o, 0);
                    check("cpl_data_ready_low", data_ready_o, 0);
                    check("cpl_busy", busy_o, 1);
`ifdef CONST_LOADER_CHECKSUM_EN
                    if (!mon_c.is_err) check("checksum", checksum_o, mon_c.csum);
`endif
                end
            end
        end
    end

    // ---------------- driver with reference model ----------------
    // mode: 0 = valid every cycle, 1 = valid every other cycle, 2 = random valid.
    task automatic run_load(input int base, input int count, input int mode, input int abort_at);
        int            guard;
        int            sent;
        bit            fin;
        bit            acc;
        bit            tog;
        logic [DW-1:0] sum;
        cpl_t          c;
        while (beats.size() < count) beats.push_back($urandom());
        guard = 0;
        @(negedge clk_i);
        while (!cmd_ready_o && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        if (!cmd_ready_o) begin
            flag("cmd_ready_timeout");
        end else begin
            cmd_valid_i     = 1'b1;
            cmd_base_addr_i = AW'(base);
            cmd_count_i     = (AW + 1)'(count);
            sum             = '0;
            if (base + count > DEPTH) begin
                c = '{is_err: 1'b1, with_write: 1'b0, csum: '0};
                cpl_q.push_back(c);
            end else if (count == 0) begin
                c = '{is_err: 1'b0, with_write: 1'b0, csum: '0};
                cpl_q.push_back(c);
            end
            @(posedge clk_i);
            @(negedge clk_i);
            cmd_valid_i = 1'b0;
            if (base + count <= DEPTH && count > 0) begin
                sent  = 0;
                fin   = 1'b0;
                guard = 0;
                tog   = 1'b1;
                while (!fin && guard < 4000) begin
                    guard++;
                    case (mode)
                        0:       data_valid_i = 1'b1;
                        1:       begin data_valid_i = tog; tog = !tog; end
                        default: data_valid_i = ($urandom_range(0, 2) != 0);
                    endcase
                    data_i  = beats[sent];
                    abort_i = data_valid_i && (sent == abort_at);
                    acc     = data_valid_i && data_ready_o;
                    @(posedge clk_i);
                    if (acc) begin
                        if (abort_i) begin
                            c = '{is_err: 1'b1, with_write: 1'b0, csum: '0};
                            cpl_q.push_back(c);
                            fin = 1'b1;
                        end else begin
                            wr_q.push_back('{addr: AW'(base + sent), data: beats[sent]});
                            sum = sum + beats[sent];
                            sent++;
                            if (sent == count) begin
                                c = '{is_err: 1'b0, with_write: 1'b1, csum: sum};
                                cpl_q.push_back(c);
                                fin = 1'b1;
                            end
                        end
                    end
                    @(negedge clk_i);
                end
                data_valid_i = 1'b0;
                abort_i      = 1'b0;
                if (!fin) flag($sformatf("load_timeout base=0x%0h count=%0d sent=%0d", base, count, sent));
            end
        end
        beats.delete();
    endtask

    // Reset lands on the 2nd beat of a 5-word load: only the 1st word may be written.
    task automatic reset_mid_load();
        @(negedge clk_i);
        cmd_valid_i     = 1'b1;
        cmd_base_addr_i = 9'h040;
        cmd_count_i     = 10'd5;
        @(posedge clk_i);
        @(negedge clk_i);
        cmd_valid_i  = 1'b0;
        data_valid_i = 1'b1;
        data_i       = 32'h1111_1111;
        check("mid_rst_data_ready", data_ready_o, 1);
        @(posedge clk_i);
        wr_q.push_back('{addr: 9'h040, data: 32'h1111_1111});
        @(negedge clk_i);
        data_i = 32'h2222_2222;
        rst_i  = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i        = 1'b0;
        data_valid_i = 1'b0;
        check("mid_rst_write_en", write_memory_en_o, 0);
        check("mid_rst_cmd_ready", cmd_ready_o, 1);
        check("mid_rst_busy", busy_o, 0);
    endtask

    initial begin
        int base;
        int count;
        int r;
        int abort_at;
        rst_i           = 1'b1;
        cmd_valid_i     = 1'b0;
        cmd_base_addr_i = '0;
        cmd_count_i     = '0;
        data_valid_i    = 1'b0;
        data_i          = '0;
        abort_i         = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;

        beats = '{32'hA, 32'hB, 32'hC, 32'hD};
        run_load(16, 4, 0, -1);
        beats = '{32'hA, 32'hB, 32'hC, 32'hD};
        run_load(16, 4, 1, -1);
        run_load(510, 2, 0, -1);
        run_load(511, 2, 0, -1);
        run_load(511, 1, 2, -1);
        run_load(291, 0, 0, -1);
        run_load(0, 512, 0, -1);
        run_load(0, 8, 0, 2);
        run_load(5, 3, 2, -1);
        reset_mid_load();
        beats = '{32'hFFFF_FFFF, 32'h0000_0002};
        run_load(256, 2, 2, -1);

        for (int i = 0; i < 40; i++) begin
            base = $urandom_range(0, DEPTH - 1);
            r    = $urandom_range(0, 9);
            if (r == 0)      count = 0;
            else if (r == 1) count = $urandom_range(0, DEPTH);
            else             count = $urandom_range(1, (DEPTH - base < 12) ? DEPTH - base : 12);
            abort_at = (count > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, count - 1) : -1;
            run_load(base, count, $urandom_range(0, 2), abort_at);
        end

        repeat (5) @(negedge clk_i);
        check("writes_outstanding", wr_q.size(), 0);
        check("completions_outstanding", cpl_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
